alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Sequencer that drives one operation at a time through an external
// 4-bit combinational ALU. Optional macro: ALU_SEQ_STICKY_OVF_EN.
module alu_sequencer #(
   parameter logic [3:0] ACC_INIT = 4'h0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_use_acc,
   output logic [3:0] alu_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_y,
   input  logic       alu_cout,
   input  logic       alu_neg,
   input  logic       alu_zero,
   input  logic       alu_ovf,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_y,
   output logic [3:0] rsp_flags,
   output logic [3:0] acc,
   output logic [7:0] op_count,
   output logic [1:0] state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never depends on ready, and payload holds while valid && !ready.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   cmd_fire;
   logic   rsp_fire;
   logic   ovf_capture;

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign state_dbg = state;

`ifdef ALU_SEQ_STICKY_OVF_EN
   // rsp_flags[0] doubles as the sticky overflow holder; only rst clears it.
   assign ovf_capture = rsp_flags[0] | alu_ovf;
`else
   assign ovf_capture = alu_ovf;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         alu_op    <= 4'h0;
         alu_a     <= 4'h0;
         alu_b     <= 4'h0;
         rsp_y     <= 4'h0;
         rsp_flags <= 4'h0;
         acc       <= ACC_INIT;
         op_count  <= 8'h00;
      end else begin
         state <= state_nxt;
         if (cmd_fire) begin
            alu_op <= cmd_op;
            alu_a  <= cmd_use_acc ? acc : cmd_a;
            alu_b  <= cmd_b;
         end
         if (state == EXEC) begin
            rsp_y     <= alu_y;
            acc       <= alu_y;
            rsp_flags <= {alu_cout, alu_neg, alu_zero, ovf_capture};
         end
         if (rsp_fire) op_count <= op_count + 8'd1;
      end
   end

endmodule
